apb_protocol_checker: RTL and testbench

Synthesizable, parametrised APB bus-protocol checker and transfer monitor that sits passively on an APB segment next to the APB interface signals. It tracks the IDLE/SETUP/ACCESS phases with an FSM and flags protocol violations in sticky and pulsed form. It counts completed reads, writes, slave errors and violations in saturating counters. Generalises the former X/Z-only property checks to a multi-slave, configurable-width block with phase tracking, stability checks and a wait-state timeout.

---
 rtl/apb_protocol_checker.sv | 233 +++++++++++++++++++++++
 tb/tb_apb_protocol_checker.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_protocol_checker.sv
// Passive APB protocol checker and transfer monitor.
// Follows the IDLE/SETUP/ACCESS phases of one APB segment, raises sticky and
// pulsed violation flags, and counts completed reads, writes, slave errors and
// violating samples in saturating counters.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no transfer in flight; a psel sample with penable=0 opens SETUP
// SETUP  | setup phase captured; next sample must be the access phase
// ACCESS | access phase seen; waiting for pready (wait timer running)
//
// err_flags bits:
//   [0] multi-hot psel   [1] penable without SETUP  [2] SETUP without ACCESS
//   [3] unstable bus     [4] ACCESS aborted         [5] wait-state timeout
module apb_protocol_checker #(
  parameter int PADDR_WIDTH  = 32,
  parameter int PWDATA_WIDTH = 32,
  parameter int NUM_SLAVES   = 16,
  parameter int TIMEOUT      = 256,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    pclock,
  input  logic                    preset,
  input  logic                    chk_en,
  input  logic                    clr,
  input  logic [PADDR_WIDTH-1:0]  paddr,
  input  logic                    prwd,
  input  logic [PWDATA_WIDTH-1:0] pwdata,
  input  logic                    penable,
  input  logic [NUM_SLAVES-1:0]   psel,
  input  logic                    pready,
  input  logic                    pslverr,
  output logic [5:0]              err_flags,
  output logic                    err_pulse,
  output logic [CNT_WIDTH-1:0]    err_count,
  output logic [CNT_WIDTH-1:0]    wr_count,
  output logic [CNT_WIDTH-1:0]    rd_count,
  output logic [CNT_WIDTH-1:0]    slverr_count,
  output logic                    busy,
  output logic [((NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1)-1:0] active_slave
);

  localparam int AW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  // Wait timer counts down from TIMEOUT; reaching zero is the timeout event.
  // A load value of zero never decrements, which disables the check.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] WAIT_LOAD = TW'(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic en);
    if (en && (v != {CNT_WIDTH{1'b1}})) return v + CNT_WIDTH'(1);
    return v;
  endfunction

  state_t                  state_q, state_d;
  logic [PADDR_WIDTH-1:0]  paddr_q, paddr_d;
  logic                    prwd_q, prwd_d;
  logic [PWDATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [NUM_SLAVES-1:0]   psel_q, psel_d;
  logic [TW-1:0]           wait_q, wait_d;
  logic [AW-1:0]           slave_q, slave_d;
  logic [5:0]              flags_q, flags_d;
  logic                    pulse_q, pulse_d;
  logic [CNT_WIDTH-1:0]    err_cnt_q, err_cnt_d;
  logic [CNT_WIDTH-1:0]    wr_cnt_q, wr_cnt_d;
  logic [CNT_WIDTH-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CNT_WIDTH-1:0]    slv_cnt_q, slv_cnt_d;

  logic [5:0]    viol;
  logic          idle_eval;
  logic          done;
  logic          sel_any;
  logic          multi_hot;
  logic          xfer_ok;
  logic          unstable;
  logic [AW-1:0] low_idx;

  assign sel_any   = |psel;
  assign multi_hot = |(psel & (psel - NUM_SLAVES'(1)));
  assign xfer_ok   = penable && sel_any;
  assign unstable  = (paddr != paddr_q) || (prwd != prwd_q) || (psel != psel_q) ||
                     (prwd_q && (pwdata != pwdata_q));

  // Index of the lowest set psel bit, reported as the active slave.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (psel[i]) low_idx = AW'(i);
    end
  end

  // Phase tracking, violation detection and next values of flags/counters.
  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    prwd_d    = prwd_q;
    pwdata_d  = pwdata_q;
    psel_d    = psel_q;
    wait_d    = wait_q;
    slave_d   = slave_q;
    viol      = '0;
    idle_eval = 1'b0;
    done      = 1'b0;

    viol[0] = multi_hot;

    case (state_q)
      ST_IDLE: idle_eval = 1'b1;
      ST_SETUP: begin
        if (xfer_ok) begin
          state_d = ST_ACCESS;
          viol[3] = unstable;
        end else begin
          viol[2]   = 1'b1;
          idle_eval = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (xfer_ok) begin
          viol[3] = unstable;
          if (pready) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end else if (wait_q != '0) begin
            wait_d  = wait_q - TW'(1);
            viol[5] = (wait_q == TW'(1));
          end
        end else begin
          viol[4]   = 1'b1;
          idle_eval = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A failed SETUP/ACCESS sample is judged again as if the bus were idle,
    // so a fresh setup phase on that same sample is still captured.
    if (idle_eval) begin
      state_d = ST_IDLE;
      if (penable) begin
        viol[1] = 1'b1;
      end else if (sel_any) begin
        state_d  = ST_SETUP;
        paddr_d  = paddr;
        prwd_d   = prwd;
        pwdata_d = pwdata;
        psel_d   = psel;
        slave_d  = low_idx;
        wait_d   = WAIT_LOAD;
      end
    end

    flags_d   = flags_q | viol;
    pulse_d   = |viol;
    err_cnt_d = sat_inc(err_cnt_q, |viol);
    wr_cnt_d  = sat_inc(wr_cnt_q, done && prwd_q);
    rd_cnt_d  = sat_inc(rd_cnt_q, done && !prwd_q);
    slv_cnt_d = sat_inc(slv_cnt_q, done && pslverr);

    if (!chk_en) begin
      state_d   = ST_IDLE;
      paddr_d   = paddr_q;
      prwd_d    = prwd_q;
      pwdata_d  = pwdata_q;
      psel_d    = psel_q;
      wait_d    = wait_q;
      slave_d   = slave_q;
      flags_d   = flags_q;
      pulse_d   = 1'b0;
      err_cnt_d = err_cnt_q;
      wr_cnt_d  = wr_cnt_q;
      rd_cnt_d  = rd_cnt_q;
      slv_cnt_d = slv_cnt_q;
    end

    // clr overrides anything computed above for this sample.
    if (clr) begin
      state_d   = ST_IDLE;
      slave_d   = slave_q;
      flags_d   = '0;
      pulse_d   = 1'b0;
      err_cnt_d = '0;
      wr_cnt_d  = '0;
      rd_cnt_d  = '0;
      slv_cnt_d = '0;
    end
  end

  // State, captured transfer and output registers.
  always_ff @(posedge pclock or negedge preset) begin
    if (!preset) begin
      state_q   <= ST_IDLE;
      paddr_q   <= '0;
      prwd_q    <= 1'b0;
      pwdata_q  <= '0;
      psel_q    <= '0;
      wait_q    <= '0;
      slave_q   <= '0;
      flags_q   <= '0;
      pulse_q   <= 1'b0;
      err_cnt_q <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      slv_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      prwd_q    <= prwd_d;
      pwdata_q  <= pwdata_d;
      psel_q    <= psel_d;
      wait_q    <= wait_d;
      slave_q   <= slave_d;
      flags_q   <= flags_d;
      pulse_q   <= pulse_d;
      err_cnt_q <= err_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      slv_cnt_q <= slv_cnt_d;
    end
  end

  assign err_flags    = flags_q;
  assign err_pulse    = pulse_q;
  assign err_count    = err_cnt_q;
  assign wr_count     = wr_cnt_q;
  assign rd_count     = rd_cnt_q;
  assign slverr_count = slv_cnt_q;
  assign busy         = (state_q != ST_IDLE);
  assign active_slave = slave_q;

endmodule

// File: tb/tb_apb_protocol_checker.sv
// Bench for apb_protocol_checker: directed scenarios followed by randomized
// APB transfers. Expected outputs come from a transfer-level model: each
// transfer is described by its shape (slave, waits, ending, defect) and the
// violations each bus sample must produce are derived from that description.
module tb_apb_protocol_checker;

  localparam int AWD  = 16;
  localparam int DW   = 32;
  localparam int NS   = 16;
  localparam int TO   = 8;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic           pclock = 1'b0;
  logic           preset = 1'b0;
  logic           chk_en = 1'b0;
  logic           clr = 1'b0;
  logic [AWD-1:0] paddr = '0;
  logic           prwd = 1'b0;
  logic [DW-1:0]  pwdata = '0;
  logic           penable = 1'b0;
  logic [NS-1:0]  psel = '0;
  logic           pready = 1'b0;
  logic           pslverr = 1'b0;
  logic [5:0]     err_flags;
  logic           err_pulse;
  logic [CW-1:0]  err_count, wr_count, rd_count, slverr_count;
  logic           busy;
  logic [3:0]     active_slave;

  apb_protocol_checker #(
    .PADDR_WIDTH(AWD), .PWDATA_WIDTH(DW), .NUM_SLAVES(NS),
    .TIMEOUT(TO), .CNT_WIDTH(CW)
  ) dut (
    .pclock(pclock), .preset(preset), .chk_en(chk_en), .clr(clr),
    .paddr(paddr), .prwd(prwd), .pwdata(pwdata), .penable(penable),
    .psel(psel), .pready(pready), .pslverr(pslverr),
    .err_flags(err_flags), .err_pulse(err_pulse), .err_count(err_count),
    .wr_count(wr_count), .rd_count(rd_count), .slverr_count(slverr_count),
    .busy(busy), .active_slave(active_slave)
  );

  always #5 pclock = ~pclock;

  int n_assert = 0;
  int n_fail   = 0;

  logic [5:0] e_flags = '0;
  logic       e_pulse = 1'b0;
  logic       e_busy  = 1'b0;
  int         e_err = 0, e_wr = 0, e_rd = 0, e_slv = 0, e_slave = 0;

  function automatic int inc(input int v);
    return (v < MAXC) ? v + 1 : v;
  endfunction

  function automatic int lowest(input logic [NS-1:0] s);
    for (int i = 0; i < NS; i++) if (s[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("err_flags", 32'(err_flags), 32'(e_flags));
    chk("err_pulse", 32'(err_pulse), 32'(e_pulse));
    chk("err_count", 32'(err_count), 32'(e_err));
    chk("wr_count", 32'(wr_count), 32'(e_wr));
    chk("rd_count", 32'(rd_count), 32'(e_rd));
    chk("slverr_count", 32'(slverr_count), 32'(e_slv));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("active_slave", 32'(active_slave), 32'(e_slave));
  endtask

  task automatic model_reset();
    e_flags = '0; e_pulse = 1'b0; e_busy = 1'b0;
    e_err = 0; e_wr = 0; e_rd = 0; e_slv = 0; e_slave = 0;
  endtask

  // One bus sample. ev: violations this sample must raise; eb: busy afterwards;
  // kind: 1 completes a write, 2 completes a read, 0 completes nothing.
  task automatic samp(input logic [NS-1:0] sel, input logic en, input logic rdy,
                      input logic serr, input logic [AWD-1:0] addr, input logic wr,
                      input logic [DW-1:0] wd, input logic [5:0] ev, input logic eb,
                      input int kind);
    @(negedge pclock);
    psel = sel; penable = en; pready = rdy; pslverr = serr;
    paddr = addr; prwd = wr; pwdata = wd;
    @(posedge pclock);
    #1;
    if (clr) begin
      e_flags = '0; e_pulse = 1'b0; e_busy = 1'b0;
      e_err = 0; e_wr = 0; e_rd = 0; e_slv = 0;
    end else if (!chk_en) begin
      e_pulse = 1'b0; e_busy = 1'b0;
    end else begin
      e_flags = e_flags | ev;
      e_pulse = |ev;
      if (|ev) e_err = inc(e_err);
      if (kind == 1) e_wr = inc(e_wr);
      if (kind == 2) e_rd = inc(e_rd);
      if (kind != 0 && serr) e_slv = inc(e_slv);
      e_busy = eb;
    end
    check_all();
  endtask

  task automatic idle_s();
    samp('0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 6'b0, 1'b0, 0);
  endtask

  task automatic clr_s();
    clr = 1'b1;
    idle_s();
    clr = 1'b0;
  endtask

  // Whole transfer. endk: 0 completes, 1 aborts after the waits, 2 drops to
  // idle straight after SETUP. chg: 1 alters paddr, 2 alters pwdata after
  // the access-entry sample (pwdata only matters on a write).
  task automatic xfer(input logic [NS-1:0] sel, input logic wr, input logic [AWD-1:0] addr,
                      input logic [DW-1:0] wd, input int waits, input int endk,
                      input logic serr, input int chg, input logic abort_en);
    logic           multi;
    logic           c3;
    logic [AWD-1:0] a2;
    logic [DW-1:0]  d2;
    logic [5:0]     ev;
    multi   = ($countones(sel) > 1);
    e_slave = lowest(sel);
    samp(sel, 1'b0, 1'b0, 1'b0, addr, wr, wd, {5'b0, multi}, 1'b1, 0);
    if (endk == 2) begin
      samp('0, 1'b0, 1'b0, 1'b0, addr, wr, wd, 6'b000100, 1'b0, 0);
      return;
    end
    samp(sel, 1'b1, 1'($urandom), 1'b0, addr, wr, wd, {5'b0, multi}, 1'b1, 0);
    a2 = (chg == 1) ? (addr ^ 16'h0004) : addr;
    d2 = (chg == 2) ? ~wd : wd;
    c3 = (chg == 1) || ((chg == 2) && wr);
    for (int k = 1; k <= waits; k++) begin
      ev = '0;
      ev[0] = multi;
      ev[3] = c3;
      ev[5] = (k == TO);
      samp(sel, 1'b1, 1'b0, 1'b0, a2, wr, d2, ev, 1'b1, 0);
    end
    if (endk == 0) begin
      ev = '0;
      ev[0] = multi;
      ev[3] = c3;
      samp(sel, 1'b1, 1'b1, serr, a2, wr, d2, ev, 1'b0, wr ? 1 : 2);
    end else begin
      ev = 6'b010000;
      ev[1] = abort_en;
      samp('0, abort_en, 1'b0, 1'b0, a2, wr, d2, ev, 1'b0, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NS-1:0] sel;
    int s1, s2, r, endk, chg;

    // Reset state.
    model_reset();
    repeat (3) @(posedge pclock);
    #1;
    check_all();
    #1 preset = 1'b1;
    chk_en = 1'b1;

    // Zero-wait write to slave 3.
    xfer(16'h0008, 1'b1, 16'h1000, 32'hA5A5_0003, 0, 0, 1'b0, 0, 1'b0);
    // Read with 4 waits and a slave error.
    xfer(16'h0020, 1'b0, 16'h2000, 32'h0, 4, 0, 1'b1, 0, 1'b0);

    // Timeout: 20 waits, flagged once; boundary of 7 waits raises nothing.
    clr_s();
    xfer(16'h0004, 1'b0, 16'h3000, 32'h0, 7, 0, 1'b0, 0, 1'b0);
    xfer(16'h0002, 1'b1, 16'h3004, 32'h1234_5678, 20, 0, 1'b0, 0, 1'b0);

    // Multi-hot psel plus paddr change during waits.
    clr_s();
    xfer(16'h0009, 1'b0, 16'h4000, 32'h0, 3, 0, 1'b0, 1, 1'b0);
    // Changing pwdata on a read is not a violation.
    xfer(16'h0040, 1'b0, 16'h4100, 32'hCAFE_0000, 2, 0, 1'b0, 2, 1'b0);

    // Stray penable, then SETUP not followed by ACCESS, then clr.
    clr_s();
    samp('0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 6'b000010, 1'b0, 0);
    xfer(16'h0010, 1'b1, 16'h5000, 32'h5, 0, 2, 1'b0, 0, 1'b0);
    clr_s();

    // Reset in the middle of ACCESS; the still-running access then raises ERR1.
    xfer(16'h0200, 1'b1, 16'h6000, 32'h6, 2, 0, 1'b0, 0, 1'b0);
    e_slave = lowest(16'h0100);
    samp(16'h0100, 1'b0, 1'b0, 1'b0, 16'h6100, 1'b1, 32'h7, 6'b0, 1'b1, 0);
    samp(16'h0100, 1'b1, 1'b0, 1'b0, 16'h6100, 1'b1, 32'h7, 6'b0, 1'b1, 0);
    samp(16'h0100, 1'b1, 1'b0, 1'b0, 16'h6100, 1'b1, 32'h7, 6'b0, 1'b1, 0);
    @(negedge pclock);
    preset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge pclock);
    #2 preset = 1'b1;
    samp(16'h0100, 1'b1, 1'b0, 1'b0, 16'h6100, 1'b1, 32'h7, 6'b000010, 1'b0, 0);

    // Monitoring disabled: nothing is flagged or counted.
    chk_en = 1'b0;
    samp('0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 6'b0, 1'b0, 0);
    samp(16'h0006, 1'b0, 1'b0, 1'b0, 16'h7000, 1'b1, 32'h1, 6'b0, 1'b0, 0);
    samp(16'h0006, 1'b1, 1'b1, 1'b1, 16'h7000, 1'b1, 32'h1, 6'b0, 1'b0, 0);
    chk_en = 1'b1;
    idle_s();

    // clr wins over a completion in the same sample.
    xfer(16'h0001, 1'b0, 16'h8000, 32'h0, 0, 0, 1'b1, 0, 1'b0);
    e_slave = 1;
    samp(16'h0002, 1'b0, 1'b0, 1'b0, 16'h8004, 1'b1, 32'h9, 6'b0, 1'b1, 0);
    samp(16'h0002, 1'b1, 1'b0, 1'b0, 16'h8004, 1'b1, 32'h9, 6'b0, 1'b1, 0);
    clr = 1'b1;
    samp(16'h0002, 1'b1, 1'b1, 1'b1, 16'h8004, 1'b1, 32'h9, 6'b0, 1'b0, 1);
    clr = 1'b0;

    // Saturation: back-to-back writes past the counter limit.
    for (int i = 0; i < MAXC + 3; i++)
      xfer(16'h8000, 1'b1, 16'(i), 32'(i), 0, 0, 1'($urandom), 0, 1'b0);

    // Randomized transfers with optional defects.
    clr_s();
    for (int t = 0; t < 60; t++) begin
      r = int'($urandom_range(0, 2));
      for (int g = 0; g < r; g++) idle_s();
      if ($urandom_range(0, 5) == 0)
        samp('0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 6'b000010, 1'b0, 0);
      s1  = int'($urandom_range(0, NS - 1));
      sel = NS'(1) << s1;
      if ($urandom_range(0, 4) == 0) begin
        s2  = (s1 + 1 + int'($urandom_range(0, NS - 2))) % NS;
        sel = sel | (NS'(1) << s2);
      end
      r    = int'($urandom_range(0, 9));
      endk = (r < 7) ? 0 : (r < 9) ? 1 : 2;
      r    = int'($urandom_range(0, 3));
      chg  = (r == 2) ? 1 : (r == 3) ? 2 : 0;
      xfer(sel, 1'($urandom), 16'($urandom), $urandom, int'($urandom_range(0, 10)),
           endk, 1'($urandom), chg, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
